seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
Shares the 2-digit 7-segment display between up to NUM_SRC requesters, such as a counter, an AD readout or a UART monitor.
- Each requester presents a 2-digit BCD value with a req/grant handshake.
- The block arbitrates round-robin with a minimum hold time (AUTO mode), or selects a source from debounced key pulses (MANUAL mode).
- It also owns digit multiplexing and BCD-to-segment decode, driving COM/SEG directly at the board top.

Parameters:
NUM_SRC, 4, number of requesters (2..8)
SEL_W, $clog2(NUM_SRC), source index width
SCAN_DIV, 50000, Sys_CLK cycles per digit slot (1 kHz per digit at 50 MHz)
HOLD_CYC, 50000000, minimum owner hold in AUTO mode before rotating (1 s)

Ports:
Sys_CLK  in  1  system clock
Sys_RST  in  1  synchronous reset, active-high
Src_Req  in  NUM_SRC  per-source display request, level
Src_Data  in  8*NUM_SRC  per-source {tens BCD, units BCD}; source i occupies bits [8i+7:8i]
Key_Out  in  2  debounced single-cycle key pulses; [0] = advance source, [1] = toggle AUTO/MANUAL
Src_Grant  out  NUM_SRC  one-hot grant, registered
Cur_Src  out  SEL_W  index of current owner or manual selection
COM  out  2  digit enables, active-low; [0] = units, [1] = tens
SEG  out  8  segments, active-low; bit0..6 = a..g, bit7 = dp

Behaviour:
- Reset (Sys_RST sampled high at an edge):
  - Src_Grant=0, Cur_Src=0, COM=2'b11, SEG=8'hFF.
  - Mode AUTO, state IDLE, round-robin pointer 0, scan and hold counters 0.
  - Reset mid-grant drops the grant at that same edge.
- Arbiter states: IDLE, GRANT, SWITCH.
- IDLE (AUTO):
  - Search Src_Req starting at the pointer, wrapping.
  - On a hit at cycle t: Src_Grant one-hot and Cur_Src are valid at t+1; state GRANT; hold counter cleared.
- GRANT (AUTO):
  - Hold counter increments and saturates at HOLD_CYC-1.
  - Owner drops Src_Req: go to SWITCH next edge regardless of hold.
  - Hold expired and another source requesting: go to SWITCH.
  - Hold expired and no other requester: keep the owner indefinitely.
- SWITCH:
  - Lasts exactly 1 cycle with Src_Grant=0.
  - Pointer = owner+1 (mod NUM_SRC).
  - Next state is IDLE, so a new grant appears 2 cycles after the SWITCH decision.
- MANUAL mode:
  - Cur_Src is the selection.
  - Src_Grant = onehot(Cur_Src) when Src_Req[Cur_Src] is high, else 0.
  - Key_Out[0] pulse: Cur_Src+1, wrapping NUM_SRC-1 to 0. Passes through one SWITCH cycle with grant 0.
- Mode toggle (Key_Out[1]):
  - AUTO to MANUAL: selection = current owner, or the pointer if IDLE.
  - MANUAL to AUTO: enter SWITCH, then IDLE search from Cur_Src+1.
- Key_Out[0] is ignored in AUTO mode.
- Simultaneous Key_Out[1] and Key_Out[0]: the toggle wins; the advance is ignored.
- Source data handling:
  - Display register loads Src_Data of the granted source every cycle while the grant is high.
  - With no grant, both digits show dash (8'hBF).
- Scan:
  - Counter runs 0..SCAN_DIV-1; on wrap the digit index toggles.
  - First cycle after reset: digit index 0, COM=2'b10 (units).
  - Digit index 1 gives COM=2'b01 (tens).
  - COM and SEG are registered together and change on the same edge.
  - Display register to SEG latency: 1 cycle.
- Decode:
  - 0..9 map to C0,F9,A4,B0,99,92,82,F8,80,90.
  - Nibbles 10..15 are blank (FF).
  - Dash is BF.
  - dp (bit7) is cleared on the tens digit while in MANUAL mode; otherwise set.

Decomposition:
- Package seg_pkg:
  - Arbiter state enum.
  - Segment constants: digit table, SEG_BLANK=8'hFF, SEG_DASH=8'hBF.
  - COM_UNITS=2'b10, COM_TENS=2'b01, COM_OFF=2'b11.
- Sub-module seg_bcd_decode: combinational 4-bit BCD to 7-seg (active-low), instantiated once on the scan-muxed nibble.
- Arbiter FSM and scan counter stay in seg_display_arbiter.

Test Plan (SCAN_DIV=4, HOLD_CYC=8, NUM_SRC=4):
1. Hold Sys_RST 3 cycles -> COM=11, SEG=FF, Src_Grant=0. After release, with no requests, COM alternates 10/01 every 4 cycles and SEG=BF.
2. Src_Req=4'b0100, Src_Data[23:16]=8'h42 from cycle t -> Src_Grant=4'b0100 and Cur_Src=2 at t+1. Units slot shows SEG=A4, tens slot shows SEG=99.
3. Src_Req=4'b1001 constant -> src0 granted. After 8 hold cycles, grant=0 for 1 cycle, then 4'b1000. After 8 more cycles, 4'b0001 again.
4. src0 owner drops Src_Req at hold count 3 while src3 requests -> grant 0 next cycle, 4'b1000 the cycle after.
5. Key_Out[1] pulse -> MANUAL, tens digit SEG bit7=0. Key_Out[0] pulse moves Cur_Src 0->1. With src1 idle, grant=0 and dashes shown. Three more pulses wrap Cur_Src to 0.
6. Key_Out=2'b11 in one cycle -> mode toggles, Cur_Src unchanged. Sys_RST asserted while granted -> Src_Grant=0, COM=11 after that edge.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the shared 2-digit 7-segment display arbiter.
// Segment patterns are active-low: bit0..6 = a..g, bit7 = dp.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_SWITCH = 2'd2
    } arb_state_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Element [d] is the pattern for digit d (listed 9 down to 0).
    localparam logic [9:0][7:0] SEG_DIGIT = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    localparam logic [1:0] COM_UNITS = 2'b10;
    localparam logic [1:0] COM_TENS  = 2'b01;
    localparam logic [1:0] COM_OFF   = 2'b11;

endpackage

// File: rtl/seg_bcd_decode.sv
// Combinational BCD nibble to active-low 7-segment pattern; 10..15 are blank.
module seg_bcd_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (bcd_i <= 4'd9) seg_o = SEG_DIGIT[bcd_i];
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Arbitrates the 2-digit display between requesters (round-robin with hold, or
// key-driven manual selection) and drives the multiplexed COM/SEG lines.
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int NUM_SRC  = 4,
    parameter int SEL_W    = $clog2(NUM_SRC),
    parameter int SCAN_DIV = 50000,
    parameter int HOLD_CYC = 50000000
) (
    input  logic                   Sys_CLK,
    input  logic                   Sys_RST,
    input  logic [NUM_SRC-1:0]     Src_Req,
    input  logic [8*NUM_SRC-1:0]   Src_Data,
    input  logic [1:0]             Key_Out,
    output logic [NUM_SRC-1:0]     Src_Grant,
    output logic [SEL_W-1:0]       Cur_Src,
    output logic [1:0]             COM,
    output logic [7:0]             SEG
);

    localparam int HOLD_W = $clog2(HOLD_CYC);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

    function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] s);
        onehot    = '0;
        onehot[s] = 1'b1;
    endfunction

    function automatic logic [SEL_W-1:0] inc(input logic [SEL_W-1:0] s);
        return (s == SEL_W'(NUM_SRC - 1)) ? '0 : s + SEL_W'(1);
    endfunction

    arb_state_e          state_q;
    logic                manual_q;
    logic [SEL_W-1:0]    ptr_q, cur_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [NUM_SRC-1:0]  grant_q;
    logic [7:0]          disp_q;
    logic                disp_vld_q;
    logic [SCAN_W-1:0]   scan_q;
    logic                dig_q;
    logic [1:0]          com_q;
    logic [7:0]          seg_q;

    // Round-robin search: rotate requests so bit 0 is the pointer position.
    logic [2*NUM_SRC-1:0] req_dbl;
    logic [NUM_SRC-1:0]   req_rot;
    logic                 hit_d, others_d;
    logic [SEL_W-1:0]     hit_idx_d, man_sel_d;
    int                   off_d, sum_d;

    assign req_dbl = {Src_Req, Src_Req};
    assign req_rot = NUM_SRC'(req_dbl >> ptr_q);

    always_comb begin
        hit_d = 1'b0;
        off_d = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!hit_d && req_rot[k]) begin
                hit_d = 1'b1;
                off_d = k;
            end
        end
        sum_d     = int'(ptr_q) + off_d;
        hit_idx_d = SEL_W'((sum_d >= NUM_SRC) ? sum_d - NUM_SRC : sum_d);
    end

    assign others_d  = |(Src_Req & ~onehot(cur_q));
    assign man_sel_d = (state_q == ST_GRANT) ? cur_q : ptr_q;

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            state_q  <= ST_IDLE;
            manual_q <= 1'b0;
            ptr_q    <= '0;
            cur_q    <= '0;
            hold_q   <= '0;
            grant_q  <= '0;
        end else if (Key_Out[1]) begin
            manual_q <= !manual_q;
            if (!manual_q) begin
                cur_q   <= man_sel_d;
                state_q <= ST_GRANT;
                grant_q <= Src_Req[man_sel_d] ? onehot(man_sel_d) : '0;
            end else begin
                state_q <= ST_SWITCH;
                grant_q <= '0;
                ptr_q   <= inc(cur_q);
            end
        end else if (manual_q) begin
            if (Key_Out[0]) begin
                cur_q   <= inc(cur_q);
                state_q <= ST_SWITCH;
                grant_q <= '0;
            end else begin
                state_q <= ST_GRANT;
                grant_q <= Src_Req[cur_q] ? onehot(cur_q) : '0;
            end
        end else begin
            case (state_q)
                ST_GRANT: begin
                    if (hold_q != HOLD_MAX) hold_q <= hold_q + HOLD_W'(1);
                    if (!Src_Req[cur_q] || (hold_q == HOLD_MAX && others_d)) begin
                        state_q <= ST_SWITCH;
                        grant_q <= '0;
                        ptr_q   <= inc(cur_q);
                    end
                end
                default: begin
                    // SWITCH searches directly so the gap stays one cycle.
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                    if (hit_d) begin
                        grant_q <= onehot(hit_idx_d);
                        cur_q   <= hit_idx_d;
                        state_q <= ST_GRANT;
                        hold_q  <= '0;
                    end
                end
            endcase
        end
    end

    logic [7:0] dec_seg, seg_base;

    seg_bcd_decode u_dec (
        .bcd_i (dig_q ? disp_q[7:4] : disp_q[3:0]),
        .seg_o (dec_seg)
    );

    assign seg_base = disp_vld_q ? dec_seg : SEG_DASH;

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            scan_q     <= '0;
            dig_q      <= 1'b0;
            com_q      <= COM_OFF;
            seg_q      <= SEG_BLANK;
            disp_q     <= '0;
            disp_vld_q <= 1'b0;
        end else begin
            scan_q <= (scan_q == SCAN_MAX) ? '0 : scan_q + SCAN_W'(1);
            if (scan_q == SCAN_MAX) dig_q <= !dig_q;
            disp_vld_q <= |grant_q;
            if (|grant_q) disp_q <= Src_Data[{cur_q, 3'b000} +: 8];
            com_q <= dig_q ? COM_TENS : COM_UNITS;
            // dp lit on the tens digit marks MANUAL mode.
            seg_q <= {seg_base[7] & !(dig_q & manual_q), seg_base[6:0]};
        end
    end

    assign Src_Grant = grant_q;
    assign Cur_Src   = cur_q;
    assign COM       = com_q;
    assign SEG       = seg_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with SCAN_DIV=4, HOLD_CYC=8, NUM_SRC=4.
module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [1:0]  key;
    logic [3:0]  grant;
    logic [1:0]  cur;
    logic [1:0]  com;
    logic [7:0]  seg;

    int tests = 0;
    int fails = 0;
    int n = 0;

    always #5 clk = ~clk;

    seg_display_arbiter #(
        .NUM_SRC  (4),
        .SCAN_DIV (4),
        .HOLD_CYC (8)
    ) dut (
        .Sys_CLK   (clk),
        .Sys_RST   (rst),
        .Src_Req   (req),
        .Src_Data  (data),
        .Key_Out   (key),
        .Src_Grant (grant),
        .Cur_Src   (cur),
        .COM       (com),
        .SEG       (seg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
        n = 0;
    endtask

    // COM after the n-th edge since reset release: 4 slots units, 4 slots tens.
    function automatic logic [1:0] exp_com(input int e);
        return (((e - 1) / 4) % 2 != 0) ? 2'b01 : 2'b10;
    endfunction

    // Check COM and SEG over 8 cycles given the units/tens patterns.
    task automatic chk_scan(input string tag, input logic [7:0] u, input logic [7:0] t);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("%s_com%0d", tag, i), com, exp_com(n));
            chk($sformatf("%s_seg%0d", tag, i), seg, (exp_com(n) == 2'b10) ? u : t);
        end
    endtask

    task automatic pulse(input logic [1:0] k);
        key = k;
        tick();
        key = 2'b00;
    endtask

    initial begin
        logic [3:0] eg;
        rst = 1'b1; req = '0; data = '0; key = '0;

        // 1: reset values, then idle scan with dashes
        do_reset(3);
        chk("rst_com", com, 2'b11);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_cur", cur, 2'd0);
        rst = 1'b0; n = 0;
        chk_scan("idle", 8'hBF, 8'hBF);

        // 2: single requester src2 shows 42
        req = 4'b0100; data = 32'h0042_0000;
        tick();
        chk("t2_grant", grant, 4'b0100);
        chk("t2_cur", cur, 2'd2);
        tick(); tick();
        chk_scan("t2", 8'hA4, 8'h99);
        req = '0;
        tick();
        chk("t2_drop", grant, 4'b0000);

        // 3: round-robin with hold between src0 and src3
        do_reset(1);
        req = 4'b1001;
        for (int i = 1; i <= 19; i++) begin
            tick();
            eg = (i <= 8) ? 4'b0001 : (i == 9) ? 4'b0000 :
                 (i <= 17) ? 4'b1000 : (i == 18) ? 4'b0000 : 4'b0001;
            chk($sformatf("rr%0d", i), grant, eg);
        end
        req = 4'b0001;
        for (int i = 0; i < 12; i++) tick();
        chk("keep_owner", grant, 4'b0001);

        // 4: owner drops early while src3 waits
        do_reset(1);
        req = 4'b0001;
        for (int i = 0; i < 4; i++) tick();
        chk("t4_own", grant, 4'b0001);
        req = 4'b1000;
        tick();
        chk("t4_gap", grant, 4'b0000);
        tick();
        chk("t4_new", grant, 4'b1000);
        chk("t4_cur", cur, 2'd3);

        // 5: manual mode, dp on tens, advance and wrap
        do_reset(1);
        req = 4'b0001; data = 32'h0000_0057;
        tick();
        pulse(2'b10);
        chk("t5_cur", cur, 2'd0);
        chk("t5_grant", grant, 4'b0001);
        tick();
        chk_scan("t5", 8'hF8, 8'h12);
        pulse(2'b01);
        chk("t5_adv_cur", cur, 2'd1);
        chk("t5_adv_gap", grant, 4'b0000);
        tick();
        chk("t5_idle_grant", grant, 4'b0000);
        tick();
        chk_scan("t5d", 8'hBF, 8'h3F);
        pulse(2'b01); tick();
        chk("t5_wrap2", cur, 2'd2);
        pulse(2'b01); tick();
        chk("t5_wrap3", cur, 2'd3);
        pulse(2'b01);
        chk("t5_wrap0", cur, 2'd0);
        tick();
        chk("t5_regrant", grant, 4'b0001);

        // 6: simultaneous keys toggle back to AUTO; reset mid-grant
        pulse(2'b11);
        chk("t6_cur", cur, 2'd0);
        chk("t6_switch", grant, 4'b0000);
        tick();
        chk("t6_auto_grant", grant, 4'b0001);
        pulse(2'b01);
        chk("t6_adv_ignored", cur, 2'd0);
        chk("t6_adv_grant", grant, 4'b0001);
        rst = 1'b1;
        tick();
        chk("t6_rst_grant", grant, 4'b0000);
        chk("t6_rst_com", com, 2'b11);
        chk("t6_rst_seg", seg, 8'hFF);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
